// File: rtl/fsic_io_serdes_pkg.sv
// Shared definitions for the FSIC IO SERDES transmit path.
//   - tx_state_e : transmit FSM encoding (idle / armed / running)
//   - Fc*        : bit positions within the fc side lane frame
//   - lane_count : number of tdata lanes for a given data width and clock ratio
package fsic_io_serdes_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StRun  = 2'd2
  } tx_state_e;

  // fc lane carries {1'b0, tlast, tvalid, tready}, one bit per phase.
  localparam int unsigned FcTlast  = 2;
  localparam int unsigned FcTvalid = 1;
  localparam int unsigned FcTready = 0;

  function automatic int unsigned lane_count(input int unsigned data_width,
                                             input int unsigned clk_ratio);
    return data_width / clk_ratio;
  endfunction

endpackage

// File: rtl/fsic_io_serdes_tx_fifo.sv
// Synchronous FIFO buffering AXIS beats ahead of the serializer.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset, empties the FIFO
//   push_i   : write wdata_i (ignored when full)
//   wdata_i  : packed beat
//   pop_i    : advance read pointer (ignored when empty)
//   rdata_o  : head entry, valid while !empty_o
//   full_o   : no free entry
//   empty_o  : no stored entry
module fsic_io_serdes_tx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddrW:0] PtrOne = 1;

  logic [Width-1:0] mem_q [Depth];
  // Extra MSB on each pointer distinguishes full from empty.
  logic [AddrW:0]   wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/fsic_io_serdes_tx.sv
// Transmit serializer for the FSIC chip-to-chip link (ioclk domain only).
// Buffers AXIS beats and emits one pCLK_RATIO-phase frame per core cycle on serial_txd,
// lane bus {fc, tid_tuser, tkeep, tstrb, tdata[L-1:0]} with L = pDATA_WIDTH/pCLK_RATIO.
// Ports:
//   ioclk, axis_rst     : clock, synchronous active-high reset
//   txen_ctl            : TX enable request (level)
//   phase_align         : marks the last coreclk phase; starts the first frame
//   as_is_*             : AXIS input beat; as_is_tready_out is the AXIS ready
//   local_tready        : flow control advertised in the fc lane
//   remote_tready       : remote flow control, 0 holds data frames back
//   txen                : TX running (clock gating enable)
//   frame_start         : phase 0 of every frame while running
//   serial_txd          : registered lane bus, all zero while not running
// Build option FSIC_IO_SERDES_TX_IDLE_ZERO_EN: idle frames carry an all-zero payload
// instead of repeating the last loaded beat.
module fsic_io_serdes_tx
  import fsic_io_serdes_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH     = 32,
  parameter int unsigned pCLK_RATIO      = 4,
  parameter int unsigned pSERIALIO_WIDTH = 12,
  parameter int unsigned pTX_FIFO_DEPTH  = 2
) (
  input  logic                       ioclk,
  input  logic                       axis_rst,
  input  logic                       txen_ctl,
  input  logic                       phase_align,
  input  logic [pDATA_WIDTH-1:0]     as_is_tdata,
  input  logic [pDATA_WIDTH/8-1:0]   as_is_tstrb,
  input  logic [pDATA_WIDTH/8-1:0]   as_is_tkeep,
  input  logic                       as_is_tlast,
  input  logic [1:0]                 as_is_tid,
  input  logic [1:0]                 as_is_tuser,
  input  logic                       as_is_tvalid,
  output logic                       as_is_tready_out,
  input  logic                       local_tready,
  input  logic                       remote_tready,
  output logic                       txen,
  output logic                       frame_start,
  output logic [pSERIALIO_WIDTH-1:0] serial_txd
);

  localparam int unsigned Lanes  = lane_count(pDATA_WIDTH, pCLK_RATIO);
  localparam int unsigned StrbW  = pDATA_WIDTH / 8;
  localparam int unsigned PhaseW = (pCLK_RATIO > 1) ? $clog2(pCLK_RATIO) : 1;
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(pCLK_RATIO - 1);
  localparam logic [PhaseW-1:0] PhaseOne  = 1;

  typedef struct packed {
    logic                   tlast;
    logic [1:0]             tid;
    logic [1:0]             tuser;
    logic [StrbW-1:0]       tkeep;
    logic [StrbW-1:0]       tstrb;
    logic [pDATA_WIDTH-1:0] tdata;
  } beat_t;

  tx_state_e                  state_q, state_d;
  logic [PhaseW-1:0]          phase_q, phase_d;
  beat_t                      payload_q, payload_d;
  logic                       tvalid_q, tvalid_d;
  logic                       tready_q, tready_d;
  logic [pSERIALIO_WIDTH-1:0] serial_q, serial_d;

  beat_t fifo_wdata, fifo_rdata;
  logic  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic  load;

  // Ready is derived from registered state only, so a pop at full cannot admit a push
  // in the same cycle.
  assign as_is_tready_out = !axis_rst && (state_q != StIdle) && !fifo_full;
  assign fifo_push        = as_is_tvalid && as_is_tready_out;

  assign fifo_wdata = '{tlast: as_is_tlast, tid: as_is_tid, tuser: as_is_tuser,
                        tkeep: as_is_tkeep, tstrb: as_is_tstrb, tdata: as_is_tdata};

  fsic_io_serdes_tx_fifo #(
    .Width ($bits(beat_t)),
    .Depth (pTX_FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (ioclk),
    .rst_i   (axis_rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // FSM, phase counter and frame load.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    payload_d = payload_q;
    tvalid_d  = tvalid_q;
    tready_d  = tready_q;
    load      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (txen_ctl) state_d = StArm;
      end
      StArm: begin
        if (!txen_ctl) begin
          state_d = StIdle;
        end else if (phase_align) begin
          state_d = StRun;
          phase_d = '0;
          load    = 1'b1;
        end
      end
      StRun: begin
        if (phase_q == PhaseLast) begin
          phase_d = '0;
          // Stop only on a frame boundary so a frame is never truncated.
          if (txen_ctl) load = 1'b1;
          else          state_d = StIdle;
        end else begin
          phase_d = phase_q + PhaseOne;
        end
      end
      default: state_d = StIdle;
    endcase

    fifo_pop = load && !fifo_empty && remote_tready;

    if (load) begin
      tready_d = local_tready;
      tvalid_d = fifo_pop;
      if (fifo_pop) begin
        payload_d = fifo_rdata;
      end else begin
`ifdef FSIC_IO_SERDES_TX_IDLE_ZERO_EN
        payload_d = '0;
`else
        payload_d = payload_q;
`endif
      end
    end
  end

  // Lane packing for the phase that will be on the wire after this edge.
  logic [Lanes-1:0][pCLK_RATIO-1:0] data_2d;
  logic [3:0]                       fc4, idu4;
  logic [pCLK_RATIO-1:0]            strb_v, keep_v, idu_v, fc_v;

  always_comb begin
    // data_2d[j][p] == tdata[j*pCLK_RATIO + p]
    data_2d        = payload_d.tdata;
    fc4            = '0;
    fc4[FcTlast]   = payload_d.tlast;
    fc4[FcTvalid]  = tvalid_d;
    fc4[FcTready]  = tready_d;
    idu4           = {payload_d.tid, payload_d.tuser};
    strb_v         = pCLK_RATIO'(payload_d.tstrb);
    keep_v         = pCLK_RATIO'(payload_d.tkeep);
    idu_v          = pCLK_RATIO'(idu4);
    fc_v           = pCLK_RATIO'(fc4);

    serial_d = '0;
    if (state_d == StRun) begin
      for (int j = 0; j < Lanes; j++) begin
        serial_d[j] = data_2d[j][phase_d];
      end
      serial_d[Lanes]     = strb_v[phase_d];
      serial_d[Lanes + 1] = keep_v[phase_d];
      serial_d[Lanes + 2] = idu_v[phase_d];
      serial_d[Lanes + 3] = fc_v[phase_d];
    end
  end

  always_ff @(posedge ioclk) begin
    if (axis_rst) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      payload_q <= '0;
      tvalid_q  <= 1'b0;
      tready_q  <= 1'b0;
      serial_q  <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      payload_q <= payload_d;
      tvalid_q  <= tvalid_d;
      tready_q  <= tready_d;
      serial_q  <= serial_d;
    end
  end

  assign txen        = (state_q == StRun);
  assign frame_start = (state_q == StRun) && (phase_q == '0);
  assign serial_txd  = serial_q;

endmodule
